orion_clk_chan_arb: RTL and testbench

- Clocked round-robin arbiter that shares one 2-phase bundled-data output channel among NREQ synchronous requesters.
- Sits at a clock-domain-to-asynchronous boundary and feeds the head of a click-based pipeline, for example a register fork.
- Each accepted word is registered, then launched by toggling out_req.
- The next grant waits until the synchronized out_ack matches out_req.

---
 rtl/orion_clk_chan_arb_if.sv | 25 ++
 rtl/orion_clk_chan_arb.sv | 139 +++++++++++++
 tb/tb_orion_clk_chan_arb.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/orion_clk_chan_arb_if.sv
// Requester-side and 2-phase output-channel signals of orion_clk_chan_arb.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface orion_clk_chan_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_req;
  logic                  out_ack;
  logic [WIDTH-1:0]      out_data;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  req_valid, req_data, out_ack,
    output req_ready, out_req, out_data, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, out_ack,
    input  req_ready, out_req, out_data, busy, timeout_err
  );
endinterface

// File: rtl/orion_clk_chan_arb.sv
// Round-robin arbiter feeding one 2-phase bundled-data channel from NREQ clocked requesters.
// Optional WAIT timeout flag is built only when ORION_CHAN_ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no word in flight; pick next valid requester from rr_ptr
// GRANT  | req_ready pulse to the winner; capture its data
// LAUNCH | out_data setup cycle; out_req toggles on exit
// WAIT   | wait for synchronized ack to match out_req
module orion_clk_chan_arb #(
  parameter int          WIDTH       = 8,
  parameter int          NREQ        = 2,
  parameter int          SYNC_STAGES = 2,
  parameter bit          REQ_INIT    = 1'b0,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input logic                  i_clk,
  input logic                  i_rst,
  orion_clk_chan_arb_if.master bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LAUNCH = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDXW-1:0]        r_gnt_idx;
  logic [IDXW-1:0]        r_rr_ptr;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_out_req;
  logic [WIDTH-1:0]       r_out_data;
  logic [NREQ-1:0]        r_req_ready;
  logic                   w_ack_s;
  logic                   w_found;
  logic [IDXW-1:0]        w_pick;

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // First valid requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && bus.req_valid[IDXW'(j)]) begin
        w_found = 1'b1;
        w_pick  = IDXW'(j);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = S_GRANT;
      S_GRANT:  w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (w_ack_s == r_out_req) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack_sync <= {SYNC_STAGES{REQ_INIT}};
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.out_ack};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
      r_out_req   <= REQ_INIT;
      r_out_data  <= '0;
      r_req_ready <= '0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_idx   <= w_pick;
            r_req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          end
        end
        S_GRANT:  r_out_data <= bus.req_data[r_gnt_idx*WIDTH +: WIDTH];
        S_LAUNCH: r_out_req  <= ~r_out_req;
        S_WAIT: begin
          if (w_ack_s == r_out_req) begin
            r_rr_ptr <= (r_gnt_idx == IDXW'(NREQ-1)) ? '0 : r_gnt_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.out_req   = r_out_req;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = (r_state != S_IDLE);

`ifdef ORION_CHAN_ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;

  // The flag is sticky; the FSM keeps waiting and a late ack still completes the word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state == S_LAUNCH) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
      if (r_wait_cnt + 16'd1 == TIMEOUT_CYC) r_timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  // Tied low; the limit parameter is still referenced so both builds share one parameter set
  assign bus.timeout_err = |(TIMEOUT_CYC & 16'h0000);
`endif

endmodule

// File: tb/tb_orion_clk_chan_arb.sv
// Randomized self-checking bench for orion_clk_chan_arb against a queue-based round-robin model.
// Define ORION_CHAN_ARB_TIMEOUT_EN for both RTL and bench to exercise the timeout flag.
module tb_orion_clk_chan_arb;
  localparam int          WIDTH = 8;
  localparam int          NREQ  = 4;
  localparam int          SYNC  = 2;
  localparam logic [15:0] TOC   = 16'd16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  orion_clk_chan_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  orion_clk_chan_arb #(
    .WIDTH(WIDTH), .NREQ(NREQ), .SYNC_STAGES(SYNC), .REQ_INIT(1'b0), .TIMEOUT_CYC(TOC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NREQ-1:0]  vld, snap, keep_mask, prev_rdy;
  logic [WIDTH-1:0] dat [NREQ];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] prev_odata;
  logic             prev_oreq;
  int  ptr, release_idx, ack_dly, ack_age, last_gnt, n_grants, n_toggles;
  bit  auto_mode, ack_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = dat[i];
    bus.req_valid = vld;
  endtask

  task automatic cycle();
    logic [NREQ-1:0]  rdy;
    int               e_idx;
    logic [WIDTH-1:0] e_dat;
    @(negedge clk);
    rdy = bus.req_ready;
    if (release_idx >= 0) begin
      if (auto_mode) begin
        vld[release_idx] = 1'($urandom_range(0, 1));
        dat[release_idx] = WIDTH'($urandom);
      end else if (!keep_mask[release_idx]) begin
        vld[release_idx] = 1'b0;
      end
      release_idx = -1;
    end
    if (ack_age >= 0) begin
      ack_age++;
      if (ack_age == SYNC) chk("busy_hold", bus.busy, 1);
      if (ack_age == SYNC + 1) begin
        chk("busy_fall", bus.busy, 0);
        ack_age = -1;
      end
    end
    if (prev_rdy != 0) chk("rdy_one_cycle", rdy, 0);
    if (rdy != 0) begin
      chk("rdy_onehot", $countones(rdy), 1);
      e_idx    = model_pick(snap, ptr);
      last_gnt = idx_of(rdy);
      chk("gnt_idx", last_gnt, e_idx);
      if (e_idx >= 0) begin
        exp_q.push_back(dat[e_idx]);
        ptr         = (e_idx + 1) % NREQ;
        release_idx = e_idx;
      end
      n_grants++;
    end
    if (bus.out_req !== prev_oreq) begin
      n_toggles++;
      if (exp_q.size() == 0) begin
        chk("spurious_toggle", 1, 0);
      end else begin
        e_dat = exp_q.pop_front();
        chk("out_data", bus.out_data, e_dat);
        chk("out_data_setup", prev_odata, e_dat);
      end
      if (!ack_hold) ack_dly = $urandom_range(0, 3);
    end
    if (ack_dly >= 0) begin
      if (ack_dly == 0) begin
        bus.out_ack = bus.out_req;
        ack_age     = 0;
        ack_dly     = -1;
      end else begin
        ack_dly--;
      end
    end
`ifndef ORION_CHAN_ARB_TIMEOUT_EN
    chk("timeout_err_low", bus.timeout_err, 0);
`endif
    prev_oreq  = bus.out_req;
    prev_odata = bus.out_data;
    prev_rdy   = rdy;
    if (auto_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1;
          dat[i] = WIDTH'($urandom);
        end
      end
    end
    drive();
    snap = vld;
  endtask

  task automatic wait_grant(input int budget);
    int g0;
    g0 = n_grants;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (n_grants != g0) return;
    end
    chk("wait_grant_expired", 0, 1);
  endtask

  task automatic wait_toggle(input int budget);
    int t0;
    t0 = n_toggles;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (n_toggles != t0) return;
    end
    chk("wait_toggle_expired", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (vld == 0 && !bus.busy && ack_dly < 0 && ack_age < 0 && release_idx < 0) return;
    end
    chk("drain_expired", 0, 1);
  endtask

  task automatic model_reset();
    ptr = 0; exp_q.delete(); vld = '0; snap = '0; keep_mask = '0; prev_rdy = '0;
    prev_oreq = 1'b0; prev_odata = '0; release_idx = -1; ack_dly = -1; ack_age = -1;
    bus.out_ack = 1'b0;
    drive();
  endtask

  initial begin
    int exp_seq [4];
    exp_seq = '{1, 0, 1, 0};
    rst = 1'b1;
    auto_mode = 1'b0; ack_hold = 1'b0; n_grants = 0; n_toggles = 0; last_gnt = -1;
    for (int i = 0; i < NREQ; i++) dat[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_req", bus.out_req, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      cycle();
      chk("idle_out_req", bus.out_req, 0);
      chk("idle_req_ready", bus.req_ready, 0);
      chk("idle_busy", bus.busy, 0);
    end

    dat[0] = 8'hA5; vld = 4'b0001; drive(); snap = vld;
    cycle();
    chk("a5_ready_latency", prev_rdy, 4'b0001);
    wait_toggle(20);
    chk("a5_out_req", bus.out_req, 1);
    drain(50);

    dat[0] = 8'h11; dat[1] = 8'h22; keep_mask = 4'b0011; vld = 4'b0011; drive(); snap = vld;
    for (int k = 0; k < 4; k++) begin
      wait_grant(40);
      chk("alt_gnt", last_gnt, exp_seq[k]);
    end
    keep_mask = '0;
    drain(80);

    dat[3] = 8'h33; vld = 4'b1000; drive(); snap = vld;
    wait_grant(40);
    chk("wrap_gnt3", last_gnt, 3);
    drain(50);
    dat[0] = 8'h44; dat[1] = 8'h55; vld = 4'b0011; drive(); snap = vld;
    wait_grant(40);
    chk("wrap_gnt0", last_gnt, 0);
    drain(80);

    auto_mode = 1'b1;
    repeat (600) cycle();
    auto_mode = 1'b0;
    drain(300);

    if (bus.out_req) begin
      dat[0] = 8'h77; vld = 4'b0001; drive(); snap = vld;
      drain(50);
    end
    ack_hold = 1'b1;
    dat[2] = 8'h5C; vld = 4'b0100; drive(); snap = vld;
    wait_toggle(30);
    repeat (2) cycle();
    chk("pre_rst_out_req", bus.out_req, 1);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_req", bus.out_req, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_out_data", bus.out_data, 0);
    ack_hold = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    dat[1] = 8'h66; dat[3] = 8'h99; vld = 4'b1010; drive(); snap = vld;
    wait_grant(40);
    chk("post_rst_gnt", last_gnt, 1);
    drain(100);

`ifdef ORION_CHAN_ARB_TIMEOUT_EN
    ack_hold = 1'b1;
    dat[0] = 8'hC3; vld = 4'b0001; drive(); snap = vld;
    wait_toggle(30);
    for (int j = 2; j <= 16; j++) cycle();
    chk("to_before_limit", bus.timeout_err, 0);
    cycle();
    chk("to_at_limit", bus.timeout_err, 1);
    repeat (5) cycle();
    chk("to_sticky", bus.timeout_err, 1);
    chk("to_still_waiting", bus.busy, 1);
    bus.out_ack = bus.out_req;
    ack_age  = 0;
    ack_hold = 1'b0;
    drain(50);
    chk("to_after_ack", bus.timeout_err, 1);
    @(negedge clk) rst = 1'b1;
    #1 chk("to_cleared_by_rst", bus.timeout_err, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;
`endif

    chk("toggles_per_word", n_toggles, n_grants);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
